// File: rtl/eth_tx_arbiter_pkg.sv
// Shared constants, FSM state encoding and width helper for the eth_tx arbiter
// and its round-robin picker.
package eth_tx_arbiter_pkg;

  localparam int BYTE_LEN               = 8;
  localparam int ETH_TX_TIMEOUT_DEFAULT = 8192;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  // ceil(log2(v)), never below 1 so that single-value ranges still get a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req starting just above
// 'last' and wrapping modulo N (N need not be a power of two).
module rr_pick
  import eth_tx_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand_idx [N];

  // cand_idx[gi] is the (gi+1)-th source after 'last'; a single subtract
  // suffices because last < N and gi+1 <= N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [W:0] sum;
      assign sum = {1'b0, last} + (W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        valid = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one eth_tx transmitter among NUM_SRC payload sources: round-robin grant,
// start pulse, byte-stream mux, and a watchdog that aborts frames that never finish.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = ETH_TX_TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC-1:0]          src_inclk,
  input  logic [NUM_SRC*BYTE_LEN-1:0] src_in,
  input  logic [NUM_SRC-1:0]          src_in_done,
  output logic [NUM_SRC-1:0]          src_readclk,
  output logic [NUM_SRC-1:0]          src_done,
  output logic [NUM_SRC-1:0]          src_err,
  output logic                        tx_start,
  output logic                        tx_rst,
  output logic                        tx_inclk,
  output logic [BYTE_LEN-1:0]         tx_in,
  output logic                        tx_in_done,
  input  logic                        tx_upstream_readclk,
  input  logic                        tx_done,
  output logic                        busy
);

  localparam int GW   = clog2_min1(NUM_SRC);
  localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_e           state_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        last_grant_q;
  logic [WD_W-1:0]      wd_cnt_q;
  logic                 tx_start_q;
  logic                 tx_rst_q;
  logic [NUM_SRC-1:0]   src_err_q;

  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic [BYTE_LEN-1:0]  src_byte [NUM_SRC];

  rr_pick #(.N(NUM_SRC), .W(GW)) u_rr_pick (
    .req   (src_req),
    .last  (last_grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_byte[gi] = src_in[gi*BYTE_LEN +: BYTE_LEN];
    end
  endgenerate

  // tx_start/tx_rst/src_err are set on the transition into START/ABORT so they
  // are high exactly while the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      wd_cnt_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_rst_q     <= 1'b0;
      src_err_q    <= '0;
    end else begin
      tx_start_q <= 1'b0;
      tx_rst_q   <= 1'b0;
      src_err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_idx;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          wd_cnt_q <= '0;
          state_q  <= ST_BUSY;
        end
        ST_BUSY: begin
          if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (tx_done) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end else if (wd_cnt_q == WD_LAST) begin
            tx_rst_q  <= 1'b1;
            src_err_q <= NUM_SRC'(1) << grant_q;
            state_q   <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          last_grant_q <= grant_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_inclk    = 1'b0;
    tx_in       = '0;
    tx_in_done  = 1'b0;
    src_readclk = '0;
    src_done    = '0;
    if (state_q == ST_BUSY) begin
      tx_inclk              = src_inclk[grant_q];
      tx_in                 = src_byte[grant_q];
      tx_in_done            = src_in_done[grant_q];
      src_readclk[grant_q]  = tx_upstream_readclk;
      src_done[grant_q]     = tx_done;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_rst   = tx_rst_q;
  assign src_err  = src_err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
